aes_decrypt_scheduler: RTL and testbench

Sequencer and two-port arbiter in front of the combinational `aes_decrypt_core` (128-bit ciphertext and key in, 128-bit plaintext out).
- Accepts decrypt jobs from two requesters over valid/ready, granting round-robin.
- Registers the selected ciphertext and key onto the core inputs and holds them for a multicycle evaluation window.
- Captures the plaintext and returns it, tagged with the requester ID, over a valid/ready response channel.
- One job is in flight at a time.
- Sits between the host/DMA front-ends and the single shared decryption datapath.

---
 rtl/aes_sched_pkg.sv | 15 +
 rtl/aes_rr_arb2.sv | 25 ++
 rtl/aes_decrypt_scheduler.sv | 96 +++++++++
 tb/tb_aes_decrypt_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES decrypt scheduler.
// Holds the FSM state enum and the datapath widths.
package aes_sched_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int REQ_ID_W        = 1;
  localparam int CORE_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: valid0/valid1 in, last_grant in, grant0/grant1 out (one-hot or none).
module aes_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (valid0 & valid1): begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end
      (valid0 & ~valid1): grant0 = 1'b1;
      (~valid0 & valid1): grant1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_decrypt_scheduler.sv
// Arbitrates two decrypt requesters onto one shared combinational AES core.
// Ports: req0/req1 valid/ready jobs in, core_* to/from core, resp_* out, busy.
module aes_decrypt_scheduler
  import aes_sched_pkg::*;
#(
  parameter int CORE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req0_cipher,
  input  logic [AES_BLK_W-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [AES_BLK_W-1:0] req1_cipher,
  input  logic [AES_BLK_W-1:0] req1_key,
  output logic [AES_BLK_W-1:0] core_cipher,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_plain,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REQ_ID_W-1:0]  resp_id,
  output logic [AES_BLK_W-1:0] resp_plain,
  output logic                 busy
);

  localparam logic [3:0] CNT_LAST = 4'(CORE_CYCLES - 1);

  sched_state_t state;
  sched_state_t state_nxt;
  logic [3:0]   cnt;
  logic         last_grant;
  logic         gnt0;
  logic         gnt1;
  logic         acc0;
  logic         acc1;
  logic         done;
  logic         resp_hs;

  aes_rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant0     (gnt0),
    .grant1     (gnt1)
  );

  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign done       = (state == EVAL) & (cnt == CNT_LAST);
  assign resp_valid = (state == RESP);
  assign resp_hs    = resp_valid & resp_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc0 | acc1) state_nxt = EVAL;
      EVAL: if (done) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      core_cipher <= '0;
      core_key    <= '0;
      resp_id     <= '0;
      resp_plain  <= '0;
    end else begin
      state <= state_nxt;
      if (acc0 | acc1) begin
        core_cipher <= acc1 ? req1_cipher : req0_cipher;
        core_key    <= acc1 ? req1_key : req0_key;
        resp_id     <= acc1;
        last_grant  <= acc1;
        cnt         <= '0;
      end
      if ((state == EVAL) && !done) cnt <= cnt + 4'd1;
      if (done) resp_plain <= core_plain;
      // key material leaves the core bus once the result is consumed
      if (resp_hs) begin
        core_cipher <= '0;
        core_key    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// Directed scoreboard bench for aes_decrypt_scheduler.
// Stub core returns FIPS-197 vectors, else cipher^key.
module tb_aes_decrypt_scheduler;
  import aes_sched_pkg::*;

  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CC = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] KC = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  function automatic logic [127:0] golden(
    input logic [127:0] c,
    input logic [127:0] k
  );
    if (c == CA && k == KA) return PA;
    if (c == CB && k == KB) return PB;
    return c ^ k;
  endfunction

  typedef struct packed {
    logic         id;
    logic [127:0] plain;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [127:0] req0_cipher = '0, req0_key = '0;
  logic [127:0] req1_cipher = '0, req1_key = '0;
  logic [127:0] core_cipher, core_key, core_plain;
  logic resp_valid, resp_ready = 1'b0;
  logic [0:0] resp_id;
  logic [127:0] resp_plain;
  logic busy;

  logic t_req0_valid = 1'b0, t_req1_valid = 1'b0;
  logic t_req0_ready, t_req1_ready;
  logic [127:0] t_cipher = CA, t_key = KA;
  logic [127:0] t_core_cipher, t_core_key, t_core_plain;
  logic t_resp_valid, t_resp_ready = 1'b1;
  logic [0:0] t_resp_id;
  logic [127:0] t_resp_plain;
  logic t_busy;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign core_plain   = golden(core_cipher, core_key);
  assign t_core_plain = golden(t_core_cipher, t_core_key);

  aes_decrypt_scheduler #(.CORE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_cipher(req0_cipher), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_cipher(req1_cipher), .req1_key(req1_key),
    .core_cipher(core_cipher), .core_key(core_key),
    .core_plain(core_plain),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_plain(resp_plain),
    .busy(busy)
  );

  aes_decrypt_scheduler #(.CORE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_req0_valid), .req0_ready(t_req0_ready),
    .req0_cipher(t_cipher), .req0_key(t_key),
    .req1_valid(t_req1_valid), .req1_ready(t_req1_ready),
    .req1_cipher(t_cipher), .req1_key(t_key),
    .core_cipher(t_core_cipher), .core_key(t_core_key),
    .core_plain(t_core_plain),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_id(t_resp_id), .resp_plain(t_resp_plain),
    .busy(t_busy)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_resp id=%0d plain=%h", resp_id, resp_plain);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_id", 128'(resp_id), 128'(mon_e.id));
        chk("resp_plain", resp_plain, mon_e.plain);
      end
    end
  end

  task automatic wait_accept(output logic id);
    logic got;
    exp_t e;
    got = 1'b0;
    id = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (req0_valid && req0_ready) begin
        got = 1'b1;
        id = 1'b0;
      end else if (req1_valid && req1_ready) begin
        got = 1'b1;
        id = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    assert (got) else begin
      failures++;
      $error("FAIL accept_timeout observed=none expected=accept");
    end
    if (got) begin
      e.id = id;
      e.plain = id ? golden(req1_cipher, req1_key)
                   : golden(req0_cipher, req0_key);
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50 && busy; i++) @(negedge clk);
    chk("idle_timeout", 128'(busy), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic id;
    int n;
    int acc[$];
    logic [127:0] pc;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_resp_plain", resp_plain, 128'(0));
    chk("rst_resp_id", 128'(resp_id), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single job, latency from accept
    resp_ready = 1'b1;
    req0_cipher = CA;
    req0_key = KA;
    req0_valid = 1'b1;
    wait_accept(id);
    req0_valid = 1'b0;
    chk("t1_grant", 128'(id), 128'(0));
    chk("t1_core_cipher", core_cipher, CA);
    chk("t1_core_key", core_key, KA);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", 128'(n - 1), 128'(3));
    wait_idle();

    // contention from reset
    do_reset();
    req0_cipher = CA;
    req0_key = KA;
    req1_cipher = CB;
    req1_key = KB;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(id);
    chk("t2_first", 128'(id), 128'(0));
    req0_valid = 1'b0;
    wait_idle();
    wait_accept(id);
    chk("t2_second", 128'(id), 128'(1));
    req1_valid = 1'b0;
    wait_idle();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(id);
    chk("t2_third", 128'(id), 128'(0));
    req0_valid = 1'b0;
    wait_idle();
    wait_accept(id);
    chk("t2_fourth", 128'(id), 128'(1));
    req1_valid = 1'b0;
    wait_idle();

    // back-pressure in RESP
    resp_ready = 1'b0;
    req0_cipher = CC;
    req0_key = KC;
    req0_valid = 1'b1;
    wait_accept(id);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    pc = golden(CC, KC);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(resp_valid), 128'(1));
      chk("bp_plain", resp_plain, pc);
      chk("bp_id", 128'(resp_id), 128'(0));
      chk("bp_ready0", 128'(req0_ready), 128'(0));
      chk("bp_ready1", 128'(req1_ready), 128'(0));
      @(negedge clk);
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_key_zero", core_key, 128'(0));
    chk("bp_cipher_zero", core_cipher, 128'(0));
    chk("bp_busy", 128'(busy), 128'(0));

    // throughput on the CORE_CYCLES=1 instance
    t_req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_req0_valid && t_req0_ready) acc.push_back(cyc);
      if (t_resp_valid) chk("tp_plain", t_resp_plain, PA);
    end
    t_req0_valid = 1'b0;
    chk("tp_accepts", 128'(acc.size() >= 4), 128'(1));
    for (int i = 1; i < acc.size(); i++)
      chk("tp_period", 128'(acc[i] - acc[i-1]), 128'(3));

    // reset during the second EVAL cycle
    req0_cipher = CA;
    req0_key = KA;
    req0_valid = 1'b1;
    wait_accept(id);
    req0_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_resp_valid", 128'(resp_valid), 128'(0));
    chk("mr_core_cipher", core_cipher, 128'(0));
    chk("mr_core_key", core_key, 128'(0));
    chk("mr_resp_plain", resp_plain, 128'(0));
    chk("mr_resp_id", 128'(resp_id), 128'(0));
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_resp", 128'(resp_valid), 128'(0));
    end
    rst_n = 1'b1;
    req1_cipher = CB;
    req1_key = KB;
    req1_valid = 1'b1;
    #1;
    chk("mr_ready1", 128'(req1_ready), 128'(1));
    chk("mr_ready0", 128'(req0_ready), 128'(0));
    wait_accept(id);
    chk("mr_grant", 128'(id), 128'(1));
    req1_valid = 1'b0;
    wait_idle();
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
